// File: rtl/blink_pkg.sv
// Shared constants for the LED blink sequencer: FSM state encoding and the
// default bit period for the board clock.
package blink_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PLAY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // One pattern bit per 0.5 s on the 50 MHz board clock
  localparam int TICK_DIV_DEFAULT = 25_000_000;

endpackage

// File: rtl/blink_tick_gen.sv
// Bit-period prescaler: counts enabled cycles 0..TICK_DIV-1 and flags the wrap
// cycle as a tick. clear has priority over enable.
module blink_tick_gen #(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;

  assign tick = enable && (cnt_q == CNT_LAST);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt_q <= '0;
    end else if (enable) begin
      cnt_q <= tick ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/blink_sequencer.sv
// LED pattern player: accepts a pattern over valid/ready and plays it MSB first,
// one bit per TICK_DIV cycles, for pat_reps passes (0 = forever) or until abort.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | pat_ready high, led off, waiting for pat_valid
//   PLAY    | pattern bit idx_q on led, prescaler running
//   DONE    | single-cycle done pulse after the last finite pass
module blink_sequencer
  import blink_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEFAULT,
  parameter int PAT_W    = 16,
  parameter int REP_W    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pat_valid,
  output logic             pat_ready,
  input  logic [PAT_W-1:0] pat_data,
  input  logic [REP_W-1:0] pat_reps,
  input  logic             abort,
  output logic             led,
  output logic             busy,
  output logic             done
);

  localparam int IDX_W = (PAT_W > 2) ? $clog2(PAT_W) : 1;
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(PAT_W - 1);
  localparam logic [REP_W-1:0] REP_ONE = REP_W'(1);

  logic [1:0]       state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [REP_W-1:0] reps_q, reps_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             led_d, busy_d, done_d, ready_d;
  logic             tick, tick_clear, tick_en;

  assign tick_en    = (state_q == ST_PLAY);
  assign tick_clear = ((state_q == ST_IDLE) && pat_valid) ||
                      ((state_q == ST_PLAY) && abort);

  blink_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk    (clk),
    .reset  (reset),
    .clear  (tick_clear),
    .enable (tick_en),
    .tick   (tick)
  );

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    reps_d  = reps_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: begin
        // abort is meaningless here, so a simultaneous pat_valid simply wins
        if (pat_valid) begin
          state_d = ST_PLAY;
          pat_d   = pat_data;
          reps_d  = pat_reps;
          idx_d   = IDX_MAX;
        end
      end
      ST_PLAY: begin
        if (abort) begin
          state_d = ST_IDLE;
          reps_d  = '0;
          idx_d   = '0;
        end else if (tick) begin
          if (idx_q != '0) begin
            idx_d = idx_q - 1'b1;
          end else if (reps_q == REP_ONE) begin
            state_d = ST_DONE;
            reps_d  = '0;
          end else begin
            // reps 0 never decrements: it means play forever
            if (reps_q != '0) begin
              reps_d = reps_q - 1'b1;
            end
            idx_d = IDX_MAX;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        reps_d  = '0;
        idx_d   = '0;
      end
    endcase
  end

  // Outputs follow the next state so they are registered without extra latency
  always_comb begin
    led_d   = (state_d == ST_PLAY) ? pat_d[idx_d] : 1'b0;
    busy_d  = (state_d == ST_PLAY);
    done_d  = (state_d == ST_DONE);
    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      pat_q     <= '0;
      reps_q    <= '0;
      idx_q     <= '0;
      led       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pat_ready <= 1'b1;
    end else begin
      state_q   <= state_d;
      pat_q     <= pat_d;
      reps_q    <= reps_d;
      idx_q     <= idx_d;
      led       <= led_d;
      busy      <= busy_d;
      done      <= done_d;
      pat_ready <= ready_d;
    end
  end

endmodule

// File: tb/tb_blink_sequencer.sv
// Self-checking bench for blink_sequencer (TICK_DIV=4, PAT_W=8, REP_W=4): table
// of directed runs, hand-written reset/handshake sequences and random patterns.
module tb_blink_sequencer;

  localparam int TD  = 4;
  localparam int PW  = 8;
  localparam int BIT_CYC = TD;
  localparam int PASS_CYC = TD * PW;

  logic       clk;
  logic       reset;
  logic       pat_valid;
  logic       pat_ready;
  logic [7:0] pat_data;
  logic [3:0] pat_reps;
  logic       abort;
  logic       led;
  logic       busy;
  logic       done;

  int vectors;
  int miscompares;

  blink_sequencer #(
    .TICK_DIV (TD),
    .PAT_W    (PW),
    .REP_W    (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .pat_valid (pat_valid),
    .pat_ready (pat_ready),
    .pat_data  (pat_data),
    .pat_reps  (pat_reps),
    .abort     (abort),
    .led       (led),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic [3:0] r;
    int         abort_at;
    int         total;
    bit         abort_with_valid;
    int         exp_on;
    int         exp_done;
  } vec_t;

  // {led, busy, done, pat_ready}
  task automatic chk(input string name, input int k, input logic [3:0] exp);
    logic [3:0] act;
    act = {led, busy, done, pat_ready};
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s k=%0d {led,busy,done,ready} got=%b want=%b", name, k, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  // Expected outputs k cycles after the accepting edge, from the pattern rules
  function automatic logic [3:0] model(input logic [7:0] d, input logic [3:0] r,
                                       input int abort_at, input int k);
    int last;
    int slot;
    last = PASS_CYC * int'(r);
    if (abort_at > 0 && k > abort_at) return 4'b0001;
    if (r != 0 && k == last + 1) return 4'b0010;
    if (r != 0 && k > last + 1) return 4'b0001;
    slot = (k - 1) / BIT_CYC;
    return {d[PW - 1 - (slot % PW)], 3'b100};
  endfunction

  // Present one pattern from IDLE and check every cycle for total cycles
  task automatic run(input string name, input logic [7:0] d, input logic [3:0] r,
                     input int abort_at, input int total, input bit abort_with_valid,
                     input int hold_from, input logic [7:0] nd, input logic [3:0] nr,
                     output int on_cnt, output int done_cnt);
    on_cnt   = 0;
    done_cnt = 0;
    pat_valid = 1'b1;
    pat_data  = d;
    pat_reps  = r;
    abort     = abort_with_valid;
    for (int k = 1; k <= total; k++) begin
      @(posedge clk);
      #1;
      pat_valid = 1'b0;
      abort     = 1'b0;
      chk(name, k, model(d, r, abort_at, k));
      if (led) on_cnt++;
      if (done) done_cnt++;
      if (k == abort_at) abort = 1'b1;
      if (hold_from > 0 && k >= hold_from) begin
        pat_valid = 1'b1;
        pat_data  = nd;
        pat_reps  = nr;
      end
    end
    abort = 1'b0;
  endtask

  vec_t tbl[6];

  initial begin
    int on_c;
    int dn_c;
    vectors     = 0;
    miscompares = 0;

    tbl[0] = '{d: 8'hB1, r: 4'd1, abort_at: 0,    total: 35,   abort_with_valid: 0, exp_on: 16,  exp_done: 1};
    tbl[1] = '{d: 8'hF0, r: 4'd3, abort_at: 0,    total: 99,   abort_with_valid: 0, exp_on: 48,  exp_done: 1};
    tbl[2] = '{d: 8'h80, r: 4'd0, abort_at: 1000, total: 1002, abort_with_valid: 0, exp_on: 128, exp_done: 0};
    tbl[3] = '{d: 8'h00, r: 4'd2, abort_at: 0,    total: 67,   abort_with_valid: 0, exp_on: 0,   exp_done: 1};
    tbl[4] = '{d: 8'hA5, r: 4'd1, abort_at: 0,    total: 35,   abort_with_valid: 1, exp_on: 16,  exp_done: 1};
    tbl[5] = '{d: 8'hFF, r: 4'd1, abort_at: 32,   total: 36,   abort_with_valid: 0, exp_on: 32,  exp_done: 0};

    reset     = 1'b1;
    pat_valid = 1'b0;
    pat_data  = '0;
    pat_reps  = '0;
    abort     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_vals", 0, 4'b0001);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_after_reset", 0, 4'b0001);

    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    chk("abort_in_idle", 0, 4'b0001);

    for (int i = 0; i < 6; i++) begin
      run($sformatf("tbl%0d", i), tbl[i].d, tbl[i].r, tbl[i].abort_at, tbl[i].total,
          tbl[i].abort_with_valid, 0, 8'h00, 4'd0, on_c, dn_c);
      chk_int($sformatf("tbl%0d_on_cycles", i), on_c, tbl[i].exp_on);
      chk_int($sformatf("tbl%0d_done_pulses", i), dn_c, tbl[i].exp_done);
    end

    // Reset held 3 cycles in the middle of a pattern
    run("pre_reset", 8'hB1, 4'd2, 0, 10, 1'b0, 0, 8'h00, 4'd0, on_c, dn_c);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("reset_mid_play", i, 4'b0001);
    end
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("post_reset_idle", i, 4'b0001);
    end

    // pat_valid held while busy must wait for IDLE, then play the new pattern
    run("hold_first", 8'hB1, 4'd1, 0, 33, 1'b0, 5, 8'hC3, 4'd1, on_c, dn_c);
    @(posedge clk);
    #1;
    chk("hold_idle_ready", 34, 4'b0001);
    run("hold_second", 8'hC3, 4'd1, 0, 35, 1'b0, 0, 8'h00, 4'd0, on_c, dn_c);
    chk_int("hold_second_on", on_c, 16);

    for (int n = 0; n < 20; n++) begin
      logic [7:0] d;
      logic [3:0] r;
      int ab;
      int tot;
      d  = 8'($urandom);
      r  = 4'($urandom_range(0, 3));
      ab = 0;
      if (r == 0 || $urandom_range(0, 1) == 1) begin
        ab = $urandom_range(1, (r == 0) ? 80 : PASS_CYC * int'(r));
      end
      tot = (ab > 0) ? ab + 3 : PASS_CYC * int'(r) + 3;
      run($sformatf("rand%0d", n), d, r, ab, tot, 1'($urandom_range(0, 1)), 0,
          8'h00, 4'd0, on_c, dn_c);
      chk_int($sformatf("rand%0d_done_pulses", n), dn_c, (ab > 0) ? 0 : 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
